// File: rtl/modmul_sched_pkg.sv
// Shared types for the modmul scheduler: FSM state encoding and the in-flight tag carried
// alongside each multiplier operation.
package modmul_sched_pkg;

  // Wide enough for the largest supported requester count (8).
  localparam int unsigned MaxIdw = 3;

  typedef enum logic [1:0] {
    StRun,
    StDrain,
    StHalt
  } sched_state_e;

  typedef struct packed {
    logic              vld;
    logic [MaxIdw-1:0] id;
  } tag_t;

endpackage

// File: rtl/modmul.sv
// Four-stage pipelined Barrett modular multiplier: dout = din_0 * din_1 % MOD.
// Output is forced to zero on cycles without a valid result.
module modmul #(
  parameter int unsigned       MWIDTH = 39,
  parameter logic [MWIDTH-1:0] MOD    = 39'h40_0080_0001,
  parameter logic [MWIDTH:0]   IMOD   = 40'd1099478074363
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_mul_vld,
  input  logic [MWIDTH-1:0] i_din_0,
  input  logic [MWIDTH-1:0] i_din_1,
  output logic [MWIDTH-1:0] o_dout
);

  localparam int unsigned PW = 2 * MWIDTH;
  localparam int unsigned QW = MWIDTH + 1;
  // Barrett remainder is below 3*MOD, so two extra bits suffice.
  localparam int unsigned RW = MWIDTH + 2;

  logic [PW-1:0]   p1_q;
  logic [RW-1:0]   p2_q;
  logic [QW-1:0]   q3_q;
  logic [RW-1:0]   r3_q;
  logic [2:0]      vld_q;
  logic [2*QW-1:0] q_full;
  logic [RW-1:0]   red;

  always_comb begin
    q_full = (2*QW)'(p1_q >> (MWIDTH - 1)) * (2*QW)'(IMOD);
    red = r3_q;
    if (red >= RW'(MOD)) red = red - RW'(MOD);
    if (red >= RW'(MOD)) red = red - RW'(MOD);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q  <= '0;
      p1_q   <= '0;
      p2_q   <= '0;
      q3_q   <= '0;
      r3_q   <= '0;
      o_dout <= '0;
    end else begin
      vld_q  <= {vld_q[1:0], i_mul_vld};
      p1_q   <= PW'(i_din_0) * PW'(i_din_1);
      p2_q   <= RW'(p1_q);
      q3_q   <= QW'(q_full >> QW);
      r3_q   <= p2_q - RW'(q3_q) * RW'(MOD);
      o_dout <= vld_q[2] ? MWIDTH'(red) : '0;
    end
  end

endmodule

// File: rtl/modmul_rr_pick.sv
// Combinational round-robin picker: first asserted request at or after ptr, wrapping at NREQ.
module modmul_rr_pick #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  idx,
  output logic            any
);

  logic [IDW-1:0] k;

  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    k   = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      k = IDW'((32'(ptr) + i) % NREQ);
      if (!any && req[k]) begin
        any    = 1'b1;
        gnt[k] = 1'b1;
        idx    = k;
      end
    end
  end

endmodule

// File: rtl/modmul_sched.sv
// Round-robin scheduler sharing one pipelined modmul among NREQ requesters, with hold/drain.
// Optional issue statistics counter enabled by defining MODMUL_SCHED_STATS_EN.
`ifndef COMMON_MODMUL_DELAY
`define COMMON_MODMUL_DELAY 4
`endif
module modmul_sched
  import modmul_sched_pkg::*;
#(
  parameter int unsigned       NREQ   = 4,
  parameter int unsigned       MWIDTH = 39,
  parameter logic [MWIDTH-1:0] MOD    = 39'h40_0080_0001,
  parameter logic [MWIDTH:0]   IMOD   = 40'd1099478074363
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NREQ-1:0]          i_req_vld,
  input  logic [NREQ*MWIDTH-1:0]   i_req_din_0,
  input  logic [NREQ*MWIDTH-1:0]   i_req_din_1,
  output logic [NREQ-1:0]          o_req_rdy,
  output logic [NREQ-1:0]          o_rsp_vld,
  output logic [$clog2(NREQ)-1:0]  o_rsp_id,
  output logic [MWIDTH-1:0]        o_rsp_dout,
  input  logic                     i_hold,
  output logic                     o_halted
`ifdef MODMUL_SCHED_STATS_EN
  ,
  input  logic                     i_stat_clr,
  output logic [31:0]              o_stat_issue_cnt
`endif
);

  localparam int unsigned IDW = $clog2(NREQ);
  localparam int unsigned LAT = `COMMON_MODMUL_DELAY;
  localparam int unsigned CW  = $clog2(LAT + 1);

  sched_state_e      state_q, state_d;
  logic [IDW-1:0]    ptr_q, ptr_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  tag_t              tag_q [LAT];
  logic [NREQ-1:0]   gnt;
  logic [IDW-1:0]    pick_idx;
  logic              pick_any;
  logic              rdy_en;
  logic              issue;
  logic              rsp;
  logic [MWIDTH-1:0] mul_a, mul_b;

  modmul_rr_pick #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_pick (
    .req (i_req_vld),
    .ptr (ptr_q),
    .gnt (gnt),
    .idx (pick_idx),
    .any (pick_any)
  );

  assign o_req_rdy = rdy_en ? gnt : '0;
  assign issue     = rdy_en & pick_any;
  assign rsp       = tag_q[LAT-1].vld;
  assign mul_a     = i_req_din_0[pick_idx*MWIDTH +: MWIDTH];
  assign mul_b     = i_req_din_1[pick_idx*MWIDTH +: MWIDTH];

  modmul #(
    .MWIDTH (MWIDTH),
    .MOD    (MOD),
    .IMOD   (IMOD)
  ) u_modmul (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_mul_vld (issue),
    .i_din_0   (mul_a),
    .i_din_1   (mul_b),
    .o_dout    (o_rsp_dout)
  );

  assign o_rsp_vld = rsp ? (NREQ'(1) << tag_q[LAT-1].id) : '0;
  assign o_rsp_id  = rsp ? IDW'(tag_q[LAT-1].id) : '0;

  always_comb begin
    ptr_d = ptr_q;
    if (issue) ptr_d = (pick_idx == IDW'(NREQ - 1)) ? '0 : pick_idx + 1'b1;
    cnt_d = cnt_q;
    if (issue && !rsp) cnt_d = cnt_q + CW'(1);
    else if (!issue && rsp) cnt_d = cnt_q - CW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StRun;
      ptr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state uses cnt_d so halt is reported the cycle right after the last result.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StRun:   if (i_hold) state_d = StDrain;
      StDrain: begin
        if (cnt_d == '0) state_d = StHalt;
        else if (!i_hold) state_d = StRun;
      end
      StHalt:  if (!i_hold) state_d = StRun;
      default: state_d = StRun;
    endcase
  end

  always_comb begin
    rdy_en   = (state_q == StRun) && !i_hold;
    o_halted = (state_q == StHalt);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LAT; i++) tag_q[i] <= '0;
    end else begin
      tag_q[0] <= '{vld: issue, id: issue ? MaxIdw'(pick_idx) : '0};
      for (int i = 1; i < LAT; i++) tag_q[i] <= tag_q[i-1];
    end
  end

`ifdef MODMUL_SCHED_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_stat_issue_cnt <= '0;
    end else if (i_stat_clr) begin
      o_stat_issue_cnt <= '0;
    end else if (issue && (o_stat_issue_cnt != 32'hFFFF_FFFF)) begin
      o_stat_issue_cnt <= o_stat_issue_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_modmul_sched.sv
// Directed bench for modmul_sched: single op, modulus boundaries, round robin, skip, hold, reset.
module tb_modmul_sched;

  localparam int unsigned NREQ = 4;
  localparam int unsigned MW   = 39;
  localparam logic [MW-1:0] MOD = 39'h40_0080_0001;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic [NREQ-1:0]      i_req_vld = '0;
  logic [NREQ*MW-1:0]   i_req_din_0 = '0;
  logic [NREQ*MW-1:0]   i_req_din_1 = '0;
  logic [NREQ-1:0]      o_req_rdy;
  logic [NREQ-1:0]      o_rsp_vld;
  logic [1:0]           o_rsp_id;
  logic [MW-1:0]        o_rsp_dout;
  logic                 i_hold = 1'b0;
  logic                 o_halted;
`ifdef MODMUL_SCHED_STATS_EN
  logic                 i_stat_clr = 1'b0;
  logic [31:0]          o_stat_issue_cnt;
`endif

  modmul_sched dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_req_vld   (i_req_vld),
    .i_req_din_0 (i_req_din_0),
    .i_req_din_1 (i_req_din_1),
    .o_req_rdy   (o_req_rdy),
    .o_rsp_vld   (o_rsp_vld),
    .o_rsp_id    (o_rsp_id),
    .o_rsp_dout  (o_rsp_dout),
    .i_hold      (i_hold),
    .o_halted    (o_halted)
`ifdef MODMUL_SCHED_STATS_EN
    ,
    .i_stat_clr       (i_stat_clr),
    .o_stat_issue_cnt (o_stat_issue_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int            c;
    int            id;
    logic [3:0]    vld;
    logic [MW-1:0] dout;
  } rsp_t;

  int   cyc = 0;
  rsp_t rq[$];
  int   gq_idx[$];
  int   gq_cyc[$];
  int   n_vec = 0;
  int   n_err = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int oh2i(logic [3:0] v);
    for (int i = 0; i < 4; i++) if (v[i]) return i;
    return -1;
  endfunction

  // Log grants and responses mid-cycle, away from the active edge.
  always @(negedge clk) begin
    if ((o_req_rdy & i_req_vld) != 0) begin
      gq_idx.push_back(oh2i(o_req_rdy & i_req_vld));
      gq_cyc.push_back(cyc);
    end
    if (o_rsp_vld != 0) rq.push_back('{cyc, int'(o_rsp_id), o_rsp_vld, o_rsp_dout});
  end

  task automatic check_val(string tag, logic [63:0] obs, logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(int k, logic [MW-1:0] a, logic [MW-1:0] b);
    i_req_din_0[k*MW +: MW] = a;
    i_req_din_1[k*MW +: MW] = b;
  endtask

  task automatic clear_logs();
    rq.delete();
    gq_idx.delete();
    gq_cyc.delete();
  endtask

  function automatic int gcyc(int j);
    return (j < gq_cyc.size()) ? gq_cyc[j] : -100;
  endfunction

  function automatic int gidx(int j);
    return (j < gq_idx.size()) ? gq_idx[j] : -1;
  endfunction

  // Response i must come from requester id with value d, LAT cycles after grant j.
  task automatic check_rsp(string tag, int i, int id, logic [MW-1:0] d, int j);
    if (i >= rq.size()) begin
      check_val({tag, "_present"}, 64'(rq.size()), 64'(i + 1));
    end else begin
      check_val({tag, "_vld"}, 64'(rq[i].vld), 64'(4'b0001 << id));
      check_val({tag, "_id"}, 64'(rq[i].id), 64'(id));
      check_val({tag, "_dout"}, 64'(rq[i].dout), 64'(d));
      check_val({tag, "_lat"}, 64'(rq[i].c), 64'(gcyc(j) + 4));
    end
  endtask

  logic [MW-1:0] ba [5];
  logic [MW-1:0] bb [5];
  logic [MW-1:0] be [5];
  logic [MW-1:0] rr_exp [4];
  int            halt_cyc;

  initial begin
    ba[0] = MOD - 1;          bb[0] = MOD - 1;       be[0] = 39'd1;
    ba[1] = 39'd0;            bb[1] = 39'd12345;     be[1] = 39'd0;
    ba[2] = 39'd1;            bb[2] = MOD - 1;       be[2] = MOD - 1;
    ba[3] = 39'h10_0000;      bb[3] = 39'h10_0000;   be[3] = 39'h3F_FE7F_FFFD;
    ba[4] = 39'h40_0000_0000; bb[4] = 39'd2;         be[4] = 39'h3F_FF7F_FFFF;
    rr_exp[0] = 39'd1000; rr_exp[1] = 39'd1111; rr_exp[2] = 39'd1224; rr_exp[3] = 39'd1339;

    repeat (2) @(posedge clk);
    #1;
    check_val("rst_rsp_vld", 64'(o_rsp_vld), 64'd0);
    check_val("rst_rsp_id", 64'(o_rsp_id), 64'd0);
    check_val("rst_rsp_dout", 64'(o_rsp_dout), 64'd0);
    check_val("rst_halted", 64'(o_halted), 64'd0);
    rst_n = 1'b1;
    tick();

    // Single op from requester 0.
    clear_logs();
    set_op(0, 39'd3, 39'd5);
    i_req_vld = 4'b0001;
    #1;
    check_val("single_rdy", 64'(o_req_rdy), 64'b0001);
    tick();
    i_req_vld = '0;
    repeat (6) tick();
    check_val("single_ngnt", 64'(gq_idx.size()), 64'd1);
    check_rsp("single", 0, 0, 39'd15, 0);
    check_val("single_nrsp", 64'(rq.size()), 64'd1);

    // Modulus boundaries, back to back from requester 2.
    clear_logs();
    i_req_vld = 4'b0100;
    for (int j = 0; j < 5; j++) begin
      set_op(2, ba[j], bb[j]);
      tick();
    end
    i_req_vld = '0;
    repeat (8) tick();
    check_val("bnd_nrsp", 64'(rq.size()), 64'd5);
    for (int j = 0; j < 5; j++) check_rsp($sformatf("bnd%0d", j), j, 2, be[j], j);

    // One op from requester 3 wraps ptr back to 0.
    clear_logs();
    set_op(3, 39'd7, 39'd9);
    i_req_vld = 4'b1000;
    tick();
    i_req_vld = '0;
    repeat (6) tick();
    check_rsp("wrap", 0, 3, 39'd63, 0);

    // Round robin with all four requesting.
    clear_logs();
    for (int k = 0; k < 4; k++) set_op(k, MW'(10 + k), MW'(100 + k));
    i_req_vld = 4'b1111;
    repeat (8) tick();
    i_req_vld = '0;
    repeat (8) tick();
    check_val("rr_ngnt", 64'(gq_idx.size()), 64'd8);
    check_val("rr_nrsp", 64'(rq.size()), 64'd8);
    for (int j = 0; j < 8; j++) begin
      check_val($sformatf("rr_gnt%0d", j), 64'(gidx(j)), 64'(j % 4));
      check_val($sformatf("rr_b2b%0d", j), 64'(gcyc(j)), 64'(gcyc(0) + j));
      check_rsp($sformatf("rr%0d", j), j, j % 4, rr_exp[j % 4], j);
    end

    // Skip idle requesters.
    clear_logs();
    set_op(1, 39'd2, 39'd3);
    set_op(3, 39'd4, 39'd5);
    i_req_vld = 4'b1010;
    repeat (4) tick();
    i_req_vld = '0;
    repeat (8) tick();
    for (int j = 0; j < 4; j++) begin
      check_val($sformatf("skip_gnt%0d", j), 64'(gidx(j)), 64'((j % 2 == 0) ? 1 : 3));
      check_rsp($sformatf("skip%0d", j), j, (j % 2 == 0) ? 1 : 3,
                (j % 2 == 0) ? 39'd6 : 39'd20, j);
    end

    // Hold with three ops in flight, then release.
    clear_logs();
    set_op(0, 39'd11, 39'd13);
    set_op(1, 39'd17, 39'd19);
    set_op(2, 39'd23, 39'd29);
    i_req_vld = 4'b0111;
    repeat (3) tick();
    i_hold = 1'b1;
    #1;
    check_val("hold_rdy", 64'(o_req_rdy), 64'd0);
    check_val("hold_not_halted", 64'(o_halted), 64'd0);
    halt_cyc = -1;
    for (int n = 0; n < 20 && halt_cyc < 0; n++) begin
      tick();
      if (o_halted) halt_cyc = cyc;
    end
    check_val("hold_ngnt", 64'(gq_idx.size()), 64'd3);
    check_val("hold_nrsp", 64'(rq.size()), 64'd3);
    check_rsp("hold0", 0, 0, 39'd143, 0);
    check_rsp("hold1", 1, 1, 39'd323, 1);
    check_rsp("hold2", 2, 2, 39'd667, 2);
    check_val("hold_halt_cyc", 64'(halt_cyc), 64'((rq.size() > 2) ? rq[2].c + 1 : -2));
    i_hold = 1'b0;
    for (int n = 0; n < 5 && gq_idx.size() < 4; n++) tick();
    check_val("resume_halted", 64'(o_halted), 64'd0);
    check_val("resume_ngnt", 64'(gq_idx.size()), 64'd4);
    check_val("resume_gnt", 64'(gidx(3)), 64'd0);
    i_req_vld = '0;
    repeat (8) tick();

    // Reset with ops in flight.
    for (int k = 0; k < 4; k++) set_op(k, MW'(k + 2), MW'(k + 3));
    i_req_vld = 4'b1111;
    repeat (4) tick();
    i_req_vld = '0;
    check_val("mid_rsp_seen", 64'(o_rsp_vld != 0), 64'd1);
    rst_n = 1'b0;
    #1;
    clear_logs();
    check_val("mid_rst_vld", 64'(o_rsp_vld), 64'd0);
    check_val("mid_rst_id", 64'(o_rsp_id), 64'd0);
    check_val("mid_rst_dout", 64'(o_rsp_dout), 64'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (8) tick();
    check_val("mid_no_stale", 64'(rq.size()), 64'd0);
    set_op(1, 39'd6, 39'd7);
    i_req_vld = 4'b0010;
    tick();
    i_req_vld = '0;
    repeat (6) tick();
    check_val("post_rst_gnt", 64'(gidx(0)), 64'd1);
    check_val("post_rst_nrsp", 64'(rq.size()), 64'd1);
    check_rsp("post_rst", 0, 1, 39'd42, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
